// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus_master initiator: FSM state encoding,
// bus-level polarity constants, default abort limit and a lane-mask helper.
package bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  // Zero the byte lanes whose enable is clear.
  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] be);
    return d & {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/bus_master_timeout.sv
// STROBE-phase abort timer: down-counter loaded with the limit minus one,
// decremented on each waited cycle; tc flags the last allowed wait cycle.
module bus_master_timeout #(
  parameter int              CNT_W = 8,
  parameter logic [CNT_W-1:0] LOAD = '1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // Reload before each STROBE phase, count down while the responder stalls.
  always_ff @(posedge clk) begin
    if (!reset_n)            cnt <= '0;
    else if (load)           cnt <= LOAD;
    else if (en && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/bus_master.sv
// 68000-style bus initiator: turns valid/ready requests into
// SETUP / STROBE / RECOVER bus cycles and returns a one-cycle response.
// Optional build macro BUS_TIMEOUT_EN adds a STROBE abort after
// TIMEOUT_CYCLES cycles without ack.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | ready for a request; be==0 requests are answered here
//   ST_SETUP   | addr/rw/data_write valid, strobes still high
//   ST_STROBE  | strobes asserted, waiting for ack low (or timeout)
//   ST_RECOVER | strobes and rw released for one cycle before IDLE
module bus_master
  import bus_master_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_be,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       data_write,
  input  logic [15:0]       data_read,
  output logic              uds,
  output logic              lds,
  output logic              rw,
  input  logic              ack
);

  state_t     state, state_nxt;
  logic [1:0] be_q;
  logic       we_q;
  logic       hs;
  logic       timed_out;
  logic       unused_addr0;

  assign hs           = req_valid && (state == ST_IDLE);
  assign req_ready    = (state == ST_IDLE);
  assign unused_addr0 = req_addr[0];

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
  logic to_tc;

  bus_master_timeout #(
    .CNT_W (TO_W),
    .LOAD  (TO_W'(TIMEOUT_CYCLES - 1))
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == ST_SETUP),
    .en      ((state == ST_STROBE) && ack),
    .tc      (to_tc)
  );

  // ack low in the terminal cycle still wins, so abort needs ack high.
  assign timed_out = (state == ST_STROBE) && ack && to_tc;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (hs && req_be != 2'b00) state_nxt = ST_SETUP;
      ST_SETUP:   state_nxt = ST_STROBE;
      ST_STROBE:  if (!ack || timed_out) state_nxt = ST_RECOVER;
      ST_RECOVER: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus drive, request latch and response generation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr       <= '0;
      data_write <= '0;
      uds        <= STROBE_OFF;
      lds        <= STROBE_OFF;
      rw         <= RW_READ;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      be_q       <= '0;
      we_q       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      busy      <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (hs) begin
            if (req_be == 2'b00) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              addr       <= {req_addr[ADDR_W-1:1], 1'b0};
              data_write <= req_wdata;
              rw         <= req_we ? RW_WRITE : RW_READ;
              be_q       <= req_be;
              we_q       <= req_we;
            end
          end
        end
        ST_SETUP: begin
          uds <= be_q[1] ? STROBE_ON : STROBE_OFF;
          lds <= be_q[0] ? STROBE_ON : STROBE_OFF;
        end
        ST_STROBE: begin
          if (!ack || timed_out) begin
            uds       <= STROBE_OFF;
            lds       <= STROBE_OFF;
            rw        <= RW_READ;
            rsp_valid <= 1'b1;
            rsp_err   <= ack;
            if (ack)       rsp_rdata <= 16'hFFFF;
            else if (we_q) rsp_rdata <= '0;
            else           rsp_rdata <= lane_mask(data_read, be_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bus_master.md
# bus_master

Synchronous initiator for the on-chip 68000-style data bus (addr, data_write, data_read, uds, lds, rw, ack). It is driven by boot/DMA logic and the debug loader. It converts single-transaction requests from a simple valid/ready port into correctly sequenced bus cycles against the boot device and SRAM responder, and returns read data and status.

## Interface
- ADDR_W, 24, bus address width
- TIMEOUT_CYCLES, 255, STROBE cycles without ack before abort (only with BUS_TIMEOUT_EN)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  byte address; bit 0 ignored
- req_we  in  1  1 = write, 0 = read
- req_be  in  2  byte enables; [1] = upper/even byte data[15:8], [0] = lower/odd byte data[7:0]
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  16  read data; disabled lanes are 0
- rsp_err  out  1  qualifies rsp_valid: rejected or timed out
- busy  out  1  state != IDLE
- addr  out  ADDR_W  bus address, bit 0 always 0
- data_write  out  16  bus write data
- data_read  in  16  bus read data
- uds, lds  out  1 each  data strobes, active-low, idle 1
- rw  out  1  1 = read, 0 = write, idle 1
- ack  in  1  active-low cycle acknowledge; 0 = complete

## Operation
- States: IDLE, SETUP, STROBE, RECOVER.
- IDLE: req_ready=1. On req_valid&req_ready, latch all req_* fields.
  - If req_be != 0, go to SETUP.
  - If req_be == 0, stay in IDLE, issue no bus activity, and pulse rsp_valid with rsp_err=1 in the next cycle.
- SETUP (1 cycle): drive addr, rw=~req_we, data_write=req_wdata. Strobes stay 1. ack is ignored.
- STROBE: uds=~be[1], lds=~be[0]. Sample ack at each clock edge.
  - ack=0: capture data_read masked by be into rsp_rdata (reads only; writes leave rsp_rdata 0). Pulse rsp_valid with rsp_err=0. Go to RECOVER.
- RECOVER (1 cycle): strobes=1, rw=1. Then go to IDLE. This guarantees at least one cycle with both strobes high between bus cycles, which responders need for strobe-edge detection.
- addr and data_write hold their last values in IDLE.
- Reset (any state): next state IDLE; the in-flight transaction is dropped with no response. Reset values: req_ready=1, busy=0, addr=0, data_write=0, uds=1, lds=1, rw=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.

## Timing
- Handshake in cycle N → SETUP in N+1 → first STROBE cycle in N+2.
- If ack=0 during N+2: rsp_valid in N+3 (RECOVER), req_ready=1 in N+4.
- Minimum 4 cycles per transaction. Back-to-back peak is 1 transaction per 4 cycles.
- Each additional wait cycle (ack=1) adds one cycle.
- All bus outputs are registered. The only combinational output is req_ready, decoded from state.
- ack already low on entry to STROBE counts as the acknowledge, giving zero wait states.

## Configuration
- BUS_TIMEOUT_EN defined:
  - An 8+ bit counter clears on STROBE entry and increments each STROBE cycle with ack=1.
  - On reaching TIMEOUT_CYCLES: rsp_valid=1, rsp_err=1, rsp_rdata=16'hFFFF, go to RECOVER.
  - ack=0 in the same cycle as the terminal count wins; the response is normal.
- BUS_TIMEOUT_EN undefined: STROBE waits for ack indefinitely, rsp_err is only set by be==0, and no counter logic is present.

## Structure
- Shared header bus_defs.vh: state encodings, RW_READ/RW_WRITE, STROBE_ON/STROBE_OFF constants, and default TIMEOUT_CYCLES.
- One sub-module, bus_timeout: counter with clear, enable and terminal-count output. Instantiated only under BUS_TIMEOUT_EN.

## Test plan
- Word write addr=0x000100, be=11, wdata=0x1234, responder acks in the first STROBE cycle → uds=lds=0 for 1 cycle, rw=0, rsp_valid at N+3 with rsp_err=0, req_ready at N+4.
- Byte read addr=0x000003, be=01, data_read=0xABCD, 2 wait states → addr=0x000002, uds=1, lds=0, rsp_rdata=0x00CD at N+5.
- Write 0xA9A9 to addr 0 be=11, then a read of 0x000000 → strobes high for ≥1 cycle between the cycles and the boot device leaves boot mode.
- req_be=00 → no strobe toggles, rsp_valid with rsp_err=1 one cycle after the handshake.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack held 1 → rsp_err=1, rsp_rdata=0xFFFF after 8 STROBE cycles, strobes released next cycle.
- reset_n=0 during STROBE → next cycle uds=lds=rw=1, busy=0, no rsp_valid; a new request completes normally.
